// File: rtl/s_sum_accumulator.sv
// ----------------------------------------------------------------------------
// s_sum_accumulator
//
// Purpose:
//   Accumulates blocks of signed samples from an upstream adder. A block ends
//   after BLOCK_LEN samples, or earlier on a sample that has in_last set. The
//   block total, sample count and a sticky overflow flag are then held on the
//   output until the downstream side takes them. After that handshake the
//   accumulator clears and the next block starts.
//
// Parameters:
//   IN_W      - width of the signed input sample
//   ACC_W     - width of the signed accumulator (must be greater than IN_W)
//   BLOCK_LEN - maximum number of samples per block (2..255)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   in_sum carries a sample
//   in_ready   out  a sample is accepted this cycle (ACCUM state)
//   in_sum     in   signed sample, IN_W bits
//   in_last    in   this sample ends the block (qualified by in_valid)
//   out_valid  out  block result is available (HOLD state)
//   out_ready  in   downstream consumes the result
//   out_acc    out  signed block total, ACC_W bits
//   out_count  out  number of samples in the block
//   out_ovf    out  an overflow occurred during the block
//
// Build option:
//   S_ACC_SATURATE_EN - when defined, the accumulator clamps to its signed
//                       limits on overflow. When undefined, it wraps modulo
//                       2^ACC_W. The overflow flag behaves the same in both
//                       builds.
// ----------------------------------------------------------------------------
module s_sum_accumulator #(
   parameter int IN_W      = 7,
   parameter int ACC_W     = 10,
   parameter int BLOCK_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [7:0]       out_count,
   output logic             out_ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [7:0]       LEN_LIMIT = 8'(BLOCK_LEN);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic [7:0]       count_q, count_d;
   logic             ovf_q,   ovf_d;

   logic             accept;
   logic [ACC_W:0]   sum_ext;
   logic [ACC_W:0]   sum_wide;
   logic             step_ovf;
   logic [7:0]       count_inc;

   // The sum is one bit wider than the accumulator, so no add can lose
   // information. The two top bits differ exactly when the sum lies outside
   // the signed ACC_W range. A sum equal to either limit leaves them equal.
   assign sum_ext   = {{(ACC_W+1-IN_W){in_sum[IN_W-1]}}, in_sum};
   assign sum_wide  = {acc_q[ACC_W-1], acc_q} + sum_ext;
   assign step_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
   assign count_inc = count_q + 8'd1;
   assign accept    = in_valid && (state_q == ACCUM);

   always_comb begin
      // NOTE: every signal gets a default before any branch. A path that
      // skipped an assignment would otherwise infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ACCUM: begin
            if (accept) begin
`ifdef S_ACC_SATURATE_EN
               // Clamp in the direction of the overflow. The next add that
               // pulls back toward zero re-enters the range naturally.
               if (step_ovf) acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
               else          acc_d = sum_wide[ACC_W-1:0];
`else
               acc_d = sum_wide[ACC_W-1:0];
`endif
               count_d = count_inc;
               ovf_d   = ovf_q | step_ovf;
               if ((count_inc == LEN_LIMIT) || in_last) state_d = HOLD;
            end
         end
         HOLD: begin
            // The result stays frozen until it is consumed. Clearing happens
            // on the same edge, so the next block sees a fresh accumulator.
            if (out_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // NOTE: the state registers use non-blocking assignments. Every flop then
   // samples the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_acc   = acc_q;
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

endmodule
